// File: rtl/switch_bounce_emulator.sv
// Emulates a bouncing mechanical contact: follows a clean commanded level through a programmable
// number of away-and-back bounces with LFSR-jittered dwell widths, then settles.
module switch_bounce_emulator #(
    parameter int unsigned MIN_WIDTH     = 4,
    parameter int unsigned JITTER_BITS   = 3,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clean_in,
    input  logic [3:0] num_bounces,
    output logic       noisy_output,
    output logic       busy,
    output logic       done,
    output logic       settled_level
);

    localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    // Counter must hold both the 13-bit dwell width and the settle length.
    localparam int unsigned SettleBits = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CntW       = (SettleBits > 13) ? SettleBits : 13;

    localparam logic [11:0]     JitterMask = 12'((32'd1 << JITTER_BITS) - 32'd1);
    localparam logic [CntW-1:0] MinLoad    = CntW'(MIN_WIDTH);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StSettle
    } state_e;

    state_e          state;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] dwell_width;
    logic [3:0]      pairs;
    logic            target;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ LfsrTaps;
        end
        dwell_width = MinLoad + CntW'(lfsr[11:0] & JitterMask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            lfsr          <= LfsrInit;
            cnt           <= '0;
            pairs         <= '0;
            target        <= 1'b0;
            noisy_output  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            settled_level <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (clean_in != settled_level) begin
                        target       <= clean_in;
                        noisy_output <= clean_in;
                        busy         <= 1'b1;
                        if (num_bounces != 4'd0) begin
                            pairs <= num_bounces;
                            cnt   <= dwell_width;
                            state <= StBounce;
                        end else begin
                            pairs <= 4'd0;
                            cnt   <= SettleLoad;
                            state <= StSettle;
                        end
                    end
                end
                StBounce: begin
                    if (cnt == CntOne) begin
                        noisy_output <= ~noisy_output;
                        // Currently away from target, so this toggle returns and closes a pair.
                        if (noisy_output != target) begin
                            if (pairs == 4'd1) begin
                                pairs <= 4'd0;
                                cnt   <= SettleLoad;
                                state <= StSettle;
                            end else begin
                                pairs <= pairs - 4'd1;
                                cnt   <= dwell_width;
                            end
                        end else begin
                            cnt <= dwell_width;
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StSettle: begin
                    if (cnt == CntOne) begin
                        done          <= 1'b1;
                        settled_level <= target;
                        busy          <= 1'b0;
                        state         <= StIdle;
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Bench for switch_bounce_emulator: fixed-width instance driven from a vector table and
// hand sequences, jittered instance driven randomly against a dwell-schedule model.
module tb_switch_bounce_emulator;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic       clean0, clean1;
    logic [3:0] nb0, nb1;
    logic       noisy0, busy0, done0, set0;
    logic       noisy1, busy1, done1, set1;

    int n_cmp = 0;
    int n_err = 0;
    int ecount1 = 0;

    localparam int TabLen = 20000;
    logic [15:0] lfsr_tab [TabLen];

    always #5 clk = ~clk;

    // Edge index since reset release; the LFSR value used at edge n is SEED advanced n times.
    always @(posedge clk) begin
        if (rst1) ecount1 <= ecount1 + 1;
    end

    switch_bounce_emulator #(
        .MIN_WIDTH(4), .JITTER_BITS(0), .SETTLE_CYCLES(8)
    ) dut0 (
        .clk(clk), .reset_n(rst0), .clean_in(clean0), .num_bounces(nb0),
        .noisy_output(noisy0), .busy(busy0), .done(done0), .settled_level(set0)
    );

    switch_bounce_emulator #(
        .MIN_WIDTH(4), .JITTER_BITS(3), .SETTLE_CYCLES(8), .SEED(16'h0001)
    ) dut1 (
        .clk(clk), .reset_n(rst1), .clean_in(clean1), .num_bounces(nb1),
        .noisy_output(noisy1), .busy(busy1), .done(done1), .settled_level(set1)
    );

    typedef struct {
        int         off;
        logic       clean;
        logic [3:0] nb;
        logic [3:0] exp;  // {noisy, busy, done, settled}
    } row_t;

    row_t rows[$];

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    logic exp_set1 = 1'b0;

    // One transition on dut1; called at the negedge before the trigger edge.
    task automatic run1(input logic t, input logic [3:0] p, input bit shape);
        int flips[$];
        int k, e, done_e, nflip, ntog, last_tog;
        logic prev_obs;
        logic [3:0] expv;
        k = ecount1;
        e = k;
        for (int i = 0; i < 2 * int'(p); i++) begin
            if (e >= TabLen) begin
                $display("FAIL lfsr_table_range: got %0d required < %0d", e, TabLen);
                $fatal(1);
            end
            e = e + 4 + int'(lfsr_tab[e] & 16'h0007);
            flips.push_back(e);
        end
        done_e = e + 8;
        ntog = 0;
        last_tog = k;
        prev_obs = t;
        for (int n = k; n <= done_e; n++) begin
            if (n == k) begin
                clean1 = t;
                nb1 = p;
            end else if (n < done_e) begin
                clean1 = 1'($urandom);
                nb1 = 4'($urandom);
            end else begin
                clean1 = t;
            end
            @(posedge clk);
            #1;
            nflip = 0;
            foreach (flips[j]) if (flips[j] <= n) nflip++;
            expv = {t ^ nflip[0], n < done_e, n == done_e, (n == done_e) ? t : exp_set1};
            check("rand_outputs", n - k, {noisy1, busy1, done1, set1}, expv);
            if (shape && n > k && noisy1 != prev_obs) begin
                ntog++;
                check("dwell_range", n - last_tog, 32'((n - last_tog) >= 4 && (n - last_tog) <= 11),
                      32'd1);
                last_tog = n;
            end
            prev_obs = noisy1;
            @(negedge clk);
        end
        if (shape) check("toggle_count", k, ntog, 2 * int'(p));
        exp_set1 = t;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_cur;
        int got;
        logic t;
        logic [15:0] v;

        v = 16'h0001;
        for (int i = 0; i < TabLen; i++) begin
            lfsr_tab[i] = v;
            v = lfsr_step(v);
        end

        rows.push_back('{0,  1'b1, 4'd2, 4'b1100});
        rows.push_back('{3,  1'b1, 4'd2, 4'b1100});
        rows.push_back('{4,  1'b1, 4'd2, 4'b0100});
        rows.push_back('{7,  1'b1, 4'd2, 4'b0100});
        rows.push_back('{8,  1'b1, 4'd7, 4'b1100});
        rows.push_back('{11, 1'b1, 4'd7, 4'b1100});
        rows.push_back('{12, 1'b1, 4'd7, 4'b0100});
        rows.push_back('{15, 1'b1, 4'd7, 4'b0100});
        rows.push_back('{16, 1'b1, 4'd7, 4'b1100});
        rows.push_back('{23, 1'b1, 4'd7, 4'b1100});
        rows.push_back('{24, 1'b1, 4'd7, 4'b1011});
        rows.push_back('{25, 1'b0, 4'd0, 4'b0101});
        rows.push_back('{32, 1'b0, 4'd0, 4'b0101});
        rows.push_back('{33, 1'b0, 4'd0, 4'b0010});
        rows.push_back('{34, 1'b0, 4'd0, 4'b0000});
        rows.push_back('{40, 1'b0, 4'd0, 4'b0000});

        // Reset behaviour, including a commanded change while held in reset.
        rst0 = 1'b0; rst1 = 1'b0;
        clean0 = 1'b0; clean1 = 1'b0; nb0 = 4'd0; nb1 = 4'd0;
        #3;
        check("reset_initial", 0, {noisy0, busy0, done0, set0}, 4'b0000);
        clean0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", i, {noisy0, busy0, done0, set0}, 4'b0000);
        end
        clean0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("after_reset", i, {noisy0, busy0, done0, set0}, 4'b0000);
            @(negedge clk);
        end

        // Table: two bounces 0->1, then 1->0 with no bounces asserted during the done cycle.
        n_cur = 0;
        foreach (rows[r]) begin
            while (n_cur < rows[r].off) begin
                @(negedge clk);
                n_cur++;
            end
            clean0 = rows[r].clean;
            nb0 = rows[r].nb;
            @(posedge clk);
            #1;
            check("table", rows[r].off, {noisy0, busy0, done0, set0}, rows[r].exp);
            @(negedge clk);
            n_cur = rows[r].off + 1;
        end

        // Glitch fully between sample edges in IDLE.
        clean0 = 1'b1;
        #1;
        clean0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_glitch", i, {noisy0, busy0, done0, set0}, 4'b0000);
            @(negedge clk);
        end

        // clean_in toggling while busy is ignored; done lands 4+4+8 edges after trigger.
        clean0 = 1'b1;
        nb0 = 4'd1;
        @(posedge clk);
        #1;
        check("busy_start", 0, {noisy0, busy0, done0, set0}, 4'b1100);
        got = -1;
        for (int c = 1; c <= 40 && got < 0; c++) begin
            @(negedge clk);
            clean0 = (c < 12) ? 1'($urandom) : 1'b1;
            nb0 = 4'($urandom);
            @(posedge clk);
            #1;
            if (done0) got = c;
        end
        check("busy_done_edge", 0, got, 16);
        check("busy_settled", 0, {busy0, set0}, 2'b01);
        @(negedge clk);
        clean0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("no_second_seq", i, {noisy0, busy0, done0, set0}, 4'b1001);
            @(negedge clk);
        end

        // Reset in the middle of a bounce.
        clean0 = 1'b0;
        nb0 = 4'd3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (i < 5) @(negedge clk);
        end
        #1;
        check("pre_reset_bounce", 5, {noisy0, busy0, done0, set0}, 4'b1101);
        #1;
        rst0 = 1'b0;
        #1;
        check("reset_mid_bounce", 0, {noisy0, busy0, done0, set0}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_mid_held", i, {noisy0, busy0, done0, set0}, 4'b0000);
        end
        rst0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            check("post_abort", i, {noisy0, busy0, done0, set0}, 4'b0000);
            @(negedge clk);
        end

        // Jittered instance: five pairs with shape checks, then random transitions.
        t = 1'b1;
        run1(t, 4'd5, 1'b1);
        for (int i = 0; i < 15; i++) begin
            t = ~t;
            run1(t, 4'($urandom_range(0, 15)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk);
                    #1;
                    check("rand_idle", g, {busy1, done1, set1}, {2'b00, exp_set1});
                    @(negedge clk);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
